// File: rtl/axi4_slave_mem_if.sv
`default_nettype none
//==============================================================================
// Module      : axi4_slave_mem_if
// Description : AXI4 bus bundle (AW/W/B/AR/R) with master and slave views.
// Revision    : 1.0 - initial release
//==============================================================================
interface axi4_slave_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [8:0]              AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [3:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [8:0]              WID;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  logic [8:0]              BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [8:0]              ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [3:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [8:0]              RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface
`default_nettype wire

// File: rtl/axi4_slave_mem.sv
`default_nettype none
//==============================================================================
// Module      : axi4_slave_mem
// Description : AXI4 slave memory; independent write/read FSMs over one array.
// Revision    : 1.0 - initial release
//==============================================================================
module axi4_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic            clk,
  input  logic            rst,
  axi4_slave_mem_if.slave axi
);

  localparam int c_NBYTES = DATA_WIDTH / 8;
  localparam int c_LOG_NB = $clog2(c_NBYTES);
  localparam int c_IDX_W  = $clog2(MEM_DEPTH);

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [ADDR_WIDTH:0]   addr_ext_t;
  typedef logic [c_IDX_W-1:0]    idx_t;

  localparam addr_ext_t  c_MEM_BYTES = addr_ext_t'(MEM_DEPTH * c_NBYTES);
  localparam logic [1:0] c_OKAY      = 2'b00;
  localparam logic [1:0] c_SLVERR    = 2'b10;
  localparam logic [1:0] c_FIXED     = 2'd0;
  localparam logic [1:0] c_INCR      = 2'd1;
  localparam logic [1:0] c_WRAP      = 2'd2;
  localparam logic [1:0] c_RSVD      = 2'd3;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [0:0] {R_IDLE, R_DATA} rstate_t;

  function automatic addr_t beat_bytes(input logic [2:0] size);
    return addr_t'(1) << size;
  endfunction

  function automatic logic out_of_range(input addr_t a);
    return {1'b0, a} >= c_MEM_BYTES;
  endfunction

  function automatic idx_t word_idx(input addr_t a);
    return a[c_LOG_NB +: c_IDX_W];
  endfunction

  // Burst-level errors decided once when the address is accepted.
  function automatic logic accept_err(input addr_t a, input logic [3:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
    addr_t b;
    logic  len_ok;
    b      = beat_bytes(size);
    len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    return (int'(size) > c_LOG_NB) || (burst == c_RSVD) ||
           ((burst == c_WRAP) && (!len_ok || ((a & (b - addr_t'(1))) != '0))) ||
           out_of_range(a);
  endfunction

  function automatic addr_t next_addr(input addr_t a, input logic [3:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
    addr_t b, total, low, nxt;
    b     = beat_bytes(size);
    total = (addr_t'(len) + addr_t'(1)) << size;
    low   = a & ~(total - addr_t'(1));
    nxt   = a;
    case (burst)
      c_INCR:  nxt = (a & ~(b - addr_t'(1))) + b;
      c_WRAP: begin
        nxt = a + b;
        if (nxt == low + total) nxt = low;
      end
      default: nxt = a;
    endcase
    return nxt;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // Write channel state
  wstate_t    r_wstate;
  logic [8:0] r_wid;
  addr_t      r_waddr;
  logic [3:0] r_wlen, r_wcnt;
  logic [2:0] r_wsize;
  logic [1:0] r_wburst;
  logic       r_werr;
  logic       r_awready, r_wready, r_bvalid;
  logic [8:0] r_bid;
  logic [1:0] r_bresp;

  logic w_wbeat, w_wlast_exp, w_wbeat_err, w_mem_we;
  logic w_unused;

  assign w_wbeat     = (r_wstate == W_DATA) && axi.WVALID && r_wready;
  assign w_wlast_exp = (r_wcnt == r_wlen);
  assign w_wbeat_err = r_werr || out_of_range(r_waddr) || (axi.WLAST != w_wlast_exp);
  assign w_mem_we    = w_wbeat && !w_wbeat_err && !rst;
  assign w_unused    = ^axi.WID;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < c_NBYTES; i++) begin
        if (axi.WSTRB[i]) r_mem[word_idx(r_waddr)][8*i +: 8] <= axi.WDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
      r_wid     <= '0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_wsize   <= '0;
      r_wburst  <= '0;
      r_werr    <= 1'b0;
    end else begin
      unique case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (axi.AWVALID && r_awready) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wid     <= axi.AWID;
            r_waddr   <= axi.AWADDR;
            r_wlen    <= axi.AWLEN;
            r_wsize   <= axi.AWSIZE;
            r_wburst  <= axi.AWBURST;
            r_wcnt    <= '0;
            r_werr    <= accept_err(axi.AWADDR, axi.AWLEN, axi.AWSIZE, axi.AWBURST);
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_wbeat) begin
            r_waddr <= next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
            r_wcnt  <= r_wcnt + 4'd1;
            r_werr  <= w_wbeat_err;
            if (w_wlast_exp) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_wid;
              r_bresp  <= w_wbeat_err ? c_SLVERR : c_OKAY;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi.BREADY) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read channel state
  rstate_t               r_rstate;
  addr_t                 r_raddr;
  logic [3:0]            r_rlen, r_rcnt;
  logic [2:0]            r_rsize;
  logic [1:0]            r_rburst;
  logic                  r_rerr;
  logic                  r_arready, r_rvalid, r_rlast;
  logic [8:0]            r_rid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  // Source of the beat about to be presented: AR fields when idle, else the burst state.
  addr_t                 w_rsrc_addr;
  logic                  w_rsrc_err;
  logic [DATA_WIDTH-1:0] w_rsrc_data;

  assign w_rsrc_addr = (r_rstate == R_IDLE) ? axi.ARADDR : r_raddr;
  assign w_rsrc_err  = (r_rstate == R_IDLE)
                     ? accept_err(axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST)
                     : (r_rerr || out_of_range(r_raddr));
  assign w_rsrc_data = w_rsrc_err ? '0 : r_mem[word_idx(w_rsrc_addr)];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rsize   <= '0;
      r_rburst  <= '0;
      r_rerr    <= 1'b0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (axi.ARVALID && r_arready) begin
            r_arready <= 1'b0;
            r_rid     <= axi.ARID;
            r_rlen    <= axi.ARLEN;
            r_rsize   <= axi.ARSIZE;
            r_rburst  <= axi.ARBURST;
            r_raddr   <= next_addr(axi.ARADDR, axi.ARLEN, axi.ARSIZE, axi.ARBURST);
            r_rerr    <= w_rsrc_err;
            r_rcnt    <= '0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rsrc_data;
            r_rresp   <= w_rsrc_err ? c_SLVERR : c_OKAY;
            r_rlast   <= (axi.ARLEN == 4'd0);
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_rvalid && axi.RREADY) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_raddr <= next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
              r_rerr  <= w_rsrc_err;
              r_rcnt  <= r_rcnt + 4'd1;
              r_rdata <= w_rsrc_data;
              r_rresp <= w_rsrc_err ? c_SLVERR : c_OKAY;
              r_rlast <= ((r_rcnt + 4'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign axi.AWREADY = r_awready;
  assign axi.WREADY  = r_wready;
  assign axi.BVALID  = r_bvalid;
  assign axi.BID     = r_bid;
  assign axi.BRESP   = r_bresp;
  assign axi.ARREADY = r_arready;
  assign axi.RVALID  = r_rvalid;
  assign axi.RID     = r_rid;
  assign axi.RDATA   = r_rdata;
  assign axi.RRESP   = r_rresp;
  assign axi.RLAST   = r_rlast;

endmodule
`default_nettype wire

// File: tb/tb_axi4_slave_mem.sv
`default_nettype none
//==============================================================================
// Module      : tb_axi4_slave_mem
// Description : Scoreboard bench for axi4_slave_mem (B/R expectations queued).
// Revision    : 1.0 - initial release
//==============================================================================
module tb_axi4_slave_mem;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MEM_DEPTH  = 1024;

  localparam logic [1:0] c_FIXED = 2'd0;
  localparam logic [1:0] c_INCR  = 2'd1;
  localparam logic [1:0] c_WRAP  = 2'd2;
  localparam logic [1:0] c_RSVD  = 2'd3;
  localparam int         c_NONE  = 99;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_slave_mem_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  axi4_slave_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .axi(bus)
  );

  typedef struct packed {
    logic [8:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct packed {
    logic [8:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  b_exp_t exp_b[$];
  r_exp_t exp_r[$];
  b_exp_t b_e;
  r_exp_t r_e;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] outs();
    return {4'h0, bus.AWREADY, bus.WREADY, bus.BVALID, bus.BID, bus.BRESP,
            bus.ARREADY, bus.RVALID, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST};
  endfunction

  // Responses are compared when the handshake is about to complete.
  always @(negedge clk) begin
    if (!rst && bus.BVALID && bus.BREADY) begin
      if (exp_b.size() == 0) check("b_unexpected", 1, 0);
      else begin
        b_e = exp_b.pop_front();
        check("bid", bus.BID, b_e.id);
        check("bresp", bus.BRESP, b_e.resp);
      end
    end
    if (!rst && bus.RVALID && bus.RREADY) begin
      if (exp_r.size() == 0) check("r_unexpected", 1, 0);
      else begin
        r_e = exp_r.pop_front();
        check("rid", bus.RID, r_e.id);
        check("rdata", bus.RDATA, r_e.data);
        check("rresp", bus.RRESP, r_e.resp);
        check("rlast", bus.RLAST, r_e.last);
      end
    end
  end

  task automatic send_aw(input logic [8:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int cyc = 0;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWBURST = burst;
    bus.AWVALID = 1'b1;
    do begin @(negedge clk); cyc++; end while (!bus.AWREADY && cyc < 50);
    check("aw_accept", bus.AWREADY, 1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [8:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int cyc = 0;
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = len; bus.ARSIZE = size; bus.ARBURST = burst;
    bus.ARVALID = 1'b1;
    do begin @(negedge clk); cyc++; end while (!bus.ARREADY && cyc < 50);
    check("ar_accept", bus.ARREADY, 1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    check("rvalid_latency", bus.RVALID, 1);
  endtask

  task automatic write_burst(input logic [8:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input logic [31:0] data [4], input logic [3:0] strb,
                             input logic [1:0] resp);
    int cyc;
    exp_b.push_back('{id: id, resp: resp});
    send_aw(id, addr, len, size, burst);
    for (int i = 0; i <= int'(len); i++) begin
      bus.WDATA  = data[i];
      bus.WSTRB  = strb;
      bus.WLAST  = (i == int'(len));
      bus.WVALID = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!bus.WREADY && cyc < 50);
      check("w_accept", bus.WREADY, 1);
      @(posedge clk); #1;
    end
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
    cyc = 0;
    while (exp_b.size() != 0 && cyc < 50) begin @(negedge clk); #1; cyc++; end
    check("b_done", exp_b.size(), 0);
    @(posedge clk); #1;
  endtask

  // Beats at index >= err_from are expected as SLVERR with zero data.
  task automatic read_burst(input logic [8:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [31:0] data [4], input int err_from);
    int cyc;
    for (int i = 0; i <= int'(len); i++)
      exp_r.push_back('{id: id, data: (i >= err_from) ? 32'h0 : data[i],
                        resp: (i >= err_from) ? 2'd2 : 2'd0, last: (i == int'(len))});
    send_ar(id, addr, len, size, burst);
    cyc = 0;
    while (exp_r.size() != 0 && cyc < 100) begin @(negedge clk); #1; cyc++; end
    check("r_beat_cycles", cyc, int'(len) + 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.AWVALID = 1'b0;
    bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs(), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("awready_before_release", bus.AWREADY, 0);
    @(posedge clk); #1;
    check("awready_after_reset", bus.AWREADY, 1);
    check("arready_after_reset", bus.ARREADY, 1);

    // Single beat write/read
    write_burst(9'd5, 32'h10, 4'd0, 3'd2, c_INCR, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, 4'hF, 2'd0);
    read_burst(9'd7, 32'h10, 4'd0, 3'd2, c_INCR, '{32'hDEADBEEF, 32'h0, 32'h0, 32'h0}, c_NONE);

    // INCR burst, back-to-back beats
    write_burst(9'd1, 32'h100, 4'd3, 3'd2, c_INCR, '{32'd1, 32'd2, 32'd3, 32'd4}, 4'hF, 2'd0);
    read_burst(9'd2, 32'h100, 4'd3, 3'd2, c_INCR, '{32'd1, 32'd2, 32'd3, 32'd4}, c_NONE);

    // WRAP read
    write_burst(9'd3, 32'h30, 4'd3, 3'd2, c_INCR, '{32'hA0, 32'hA1, 32'hA2, 32'hA3}, 4'hF, 2'd0);
    read_burst(9'd4, 32'h38, 4'd3, 3'd2, c_WRAP, '{32'hA2, 32'hA3, 32'hA0, 32'hA1}, c_NONE);

    // Byte strobes
    write_burst(9'd6, 32'h20, 4'd0, 3'd2, c_INCR, '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0}, 4'hF, 2'd0);
    write_burst(9'd6, 32'h20, 4'd0, 3'd2, c_INCR, '{32'h11223344, 32'h0, 32'h0, 32'h0}, 4'h5, 2'd0);
    read_burst(9'd8, 32'h20, 4'd0, 3'd2, c_INCR, '{32'hFF22FF44, 32'h0, 32'h0, 32'h0}, c_NONE);

    // Out of range: no write, low words (aliases of the index) untouched
    write_burst(9'd9, 32'h0, 4'd1, 3'd2, c_INCR, '{32'h0BADF00D, 32'h12345678, 32'h0, 32'h0}, 4'hF, 2'd0);
    write_burst(9'd10, 32'h1000, 4'd1, 3'd2, c_INCR, '{32'h55, 32'h66, 32'h0, 32'h0}, 4'hF, 2'd2);
    read_burst(9'd11, 32'h1000, 4'd1, 3'd2, c_INCR, '{32'h0, 32'h0, 32'h0, 32'h0}, 0);
    read_burst(9'd12, 32'h0, 4'd1, 3'd2, c_INCR, '{32'h0BADF00D, 32'h12345678, 32'h0, 32'h0}, c_NONE);

    // Burst running off the top of memory: error from beat 2 onward
    write_burst(9'd13, 32'hFF8, 4'd3, 3'd2, c_INCR, '{32'hC1, 32'hC2, 32'hC3, 32'hC4}, 4'hF, 2'd2);
    read_burst(9'd14, 32'hFF8, 4'd3, 3'd2, c_INCR, '{32'hC1, 32'hC2, 32'h0, 32'h0}, 2);

    // Illegal burst shapes
    write_burst(9'd15, 32'h40, 4'd0, 3'd2, c_INCR, '{32'h40404040, 32'h0, 32'h0, 32'h0}, 4'hF, 2'd0);
    write_burst(9'd16, 32'h40, 4'd2, 3'd2, c_WRAP, '{32'h99, 32'h98, 32'h97, 32'h0}, 4'hF, 2'd2);
    read_burst(9'd17, 32'h40, 4'd0, 3'd2, c_INCR, '{32'h40404040, 32'h0, 32'h0, 32'h0}, c_NONE);
    read_burst(9'd18, 32'h10, 4'd0, 3'd3, c_INCR, '{32'h0, 32'h0, 32'h0, 32'h0}, 0);
    read_burst(9'd19, 32'h10, 4'd0, 3'd2, c_RSVD, '{32'h0, 32'h0, 32'h0, 32'h0}, 0);
    read_burst(9'd20, 32'h12, 4'd1, 3'd2, c_WRAP, '{32'h0, 32'h0, 32'h0, 32'h0}, 0);

    // FIXED burst keeps hitting one word
    write_burst(9'd21, 32'h50, 4'd2, 3'd2, c_FIXED, '{32'd7, 32'd8, 32'd9, 32'd0}, 4'hF, 2'd0);
    read_burst(9'd22, 32'h50, 4'd1, 3'd2, c_FIXED, '{32'd9, 32'd9, 32'd0, 32'd0}, c_NONE);

    // Backpressure on the last beat
    for (int i = 0; i < 4; i++)
      exp_r.push_back('{id: 9'd23, data: 32'(i + 1), resp: 2'd0, last: (i == 3)});
    send_ar(9'd23, 32'h100, 4'd3, 3'd2, c_INCR);
    repeat (3) @(posedge clk);
    #1;
    bus.RREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rvalid", bus.RVALID, 1);
      check("bp_rdata", bus.RDATA, 32'd4);
      check("bp_rlast", bus.RLAST, 1);
    end
    bus.RREADY = 1'b1;
    begin
      int cyc = 0;
      while (exp_r.size() != 0 && cyc < 20) begin @(negedge clk); #1; cyc++; end
      check("bp_drain", exp_r.size(), 0);
    end
    @(posedge clk); #1;

    // Reset in the middle of a write burst
    send_aw(9'd24, 32'h200, 4'd1, 3'd2, c_INCR);
    bus.WDATA = 32'hAAAA; bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
    begin
      int cyc = 0;
      do begin @(negedge clk); cyc++; end while (!bus.WREADY && cyc < 50);
      check("rst_w_accept", bus.WREADY, 1);
    end
    @(posedge clk); #1;
    bus.WVALID = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_outputs", outs(), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_awready_low", bus.AWREADY, 0);
    @(posedge clk); #1;
    check("rst_mid_awready", bus.AWREADY, 1);
    repeat (4) @(negedge clk);
    check("rst_mid_no_bvalid", bus.BVALID, 0);
    @(posedge clk); #1;

    write_burst(9'd25, 32'h200, 4'd0, 3'd2, c_INCR, '{32'h5A5A5A5A, 32'h0, 32'h0, 32'h0}, 4'hF, 2'd0);
    read_burst(9'd26, 32'h200, 4'd0, 3'd2, c_INCR, '{32'h5A5A5A5A, 32'h0, 32'h0, 32'h0}, c_NONE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
